// File: rtl/riscv_zero_pkg.sv
// Shared definitions for the riscv_zero core front end.
package riscv_zero_pkg;

  // Canonical NOP: addi x0, x0, 0.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,    // no request in flight
    StWait,    // request in flight, data will be kept
    StDiscard  // request in flight, data will be dropped
  } fetch_state_e;

endpackage

// File: rtl/riscv_zero_fetch_buffer.sv
// Two-entry FIFO of {pc, inst} pairs between fetch and decode.
// The head is read straight from storage, so it is registered.
module riscv_zero_fetch_buffer
  import riscv_zero_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [63:0] push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [63:0] head_data_o,
  output logic [1:0]  count_o
);

  logic [63:0] mem_q [2];
  logic [63:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  // Pointer/count update; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != 2'd0);
    // When full, a push is only accepted together with a pop (the slot frees this cycle).
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/riscv_zero_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem request at a time,
// buffers returned words and handles redirects from execute.
module riscv_zero_fetch
  import riscv_zero_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] pc_out_o,
  output logic        inst_valid_o
);

  fetch_state_e state_q, state_d;
  // addr_q is the in-flight address, or the next address to fetch while idle.
  logic [31:0]  addr_q, addr_d;
  // Pending redirect target while the dropped request drains.
  logic [31:0]  target_q, target_d;
  logic         req_q, req_d;

  logic [31:0]  redirect_tgt;
  logic         ack_ok;
  logic         push, pop, flush;
  logic [1:0]   count;
  logic [1:0]   count_after;
  logic         can_issue;
  logic [63:0]  head_data;

  assign redirect_tgt = redirect_pc_i & ~32'd3;

  // Handshake decode: what the queue does this cycle and whether another request fits.
  always_comb begin
    // Acks without an outstanding request are stale and ignored.
    ack_ok      = imem_ack_i && req_q;
    flush       = redirect_i;
    pop         = inst_valid_o && !stall_i && !redirect_i;
    push        = (state_q == StWait) && ack_ok && !redirect_i;
    count_after = count + {1'b0, push} - {1'b0, pop};
    can_issue   = (count_after <= 2'd1);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      req_q    <= req_d;
    end
  end

  // Next-state and fetch PC logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_i) begin
          addr_d  = redirect_tgt;
          state_d = StWait;
        end else if (can_issue) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_i) begin
          if (ack_ok) begin
            addr_d  = redirect_tgt;
            state_d = StWait;
          end else begin
            // The in-flight request cannot be aborted; keep its address and drop its data.
            target_d = redirect_tgt;
            state_d  = StDiscard;
          end
        end else if (ack_ok) begin
          addr_d  = addr_q + 32'd4;
          state_d = can_issue ? StWait : StIdle;
        end
      end
      StDiscard: begin
        if (ack_ok) begin
          addr_d  = redirect_i ? redirect_tgt : target_q;
          state_d = StWait;
        end else if (redirect_i) begin
          target_d = redirect_tgt;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic: request flag follows the next state so imem_req is registered.
  always_comb begin
    req_d        = (state_d != StIdle);
    inst_valid_o = (count != 2'd0);
    inst_data_o  = inst_valid_o ? head_data[31:0]  : RV_NOP;
    pc_out_o     = inst_valid_o ? head_data[63:32] : 32'h0;
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

  riscv_zero_fetch_buffer u_buffer (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({addr_q, imem_rdata_i}),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_data_o (head_data),
    .count_o     (count)
  );

endmodule

// File: tb/tb_riscv_zero_fetch.sv
// Directed bench for riscv_zero_fetch; a second instance checks PC wrap-around.
module tb_riscv_zero_fetch;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_data;
  logic [31:0] pc_out;
  logic        inst_valid;

  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic [31:0] inst_data_w;
  logic [31:0] pc_out_w;
  logic        inst_valid_w;

  int n_tests;
  int n_fail;

  localparam logic [31:0] Nop = 32'h0000_0013;

  riscv_zero_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .inst_data_o   (inst_data),
    .pc_out_o      (pc_out),
    .inst_valid_o  (inst_valid)
  );

  riscv_zero_fetch #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_w),
    .imem_addr_o   (imem_addr_w),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .inst_data_o   (inst_data_w),
    .pc_out_o      (pc_out_w),
    .inst_valid_o  (inst_valid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},   {31'd0, imem_req},   32'd0);
    check_val({tag, "_addr"},  imem_addr,           32'h0);
    check_val({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    check_val({tag, "_data"},  inst_data,           Nop);
    check_val({tag, "_pc"},    pc_out,              32'h0);
  endtask

  // Single-cycle memory returning the address as data.
  task automatic mem_respond();
    imem_ack   = imem_req;
    imem_rdata = imem_addr;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] exp_pc;
    logic [31:0] wrap_addr [3];
    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check_val("rst_wrap_addr", imem_addr_w, 32'hFFFF_FFF8);
    reset = 1'b0;

    // Free run: one instruction per cycle.
    exp_pc = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("run_req", {31'd0, imem_req}, 32'd1);
      check_val("run_addr", imem_addr, 32'(k * 4));
      if (k == 0) begin
        check_val("run_first_valid", {31'd0, inst_valid}, 32'd0);
      end else begin
        check_val("run_valid", {31'd0, inst_valid}, 32'd1);
        check_val("run_pc", pc_out, exp_pc);
        check_val("run_data", inst_data, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (k < 3) check_val("wrap_addr", imem_addr_w, wrap_addr[k]);
      if (k == 1) check_val("wrap_pc0", pc_out_w, 32'hFFFF_FFF8);
      if (k == 2) check_val("wrap_pc1", pc_out_w, 32'hFFFF_FFFC);
      mem_respond();
    end

    // Backpressure: queue fills, request drops, head holds.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 1'b1;
      check_val("stall_valid", {31'd0, inst_valid}, 32'd1);
      check_val("stall_head", pc_out, exp_pc);
      if (i > 0) check_val("stall_req_low", {31'd0, imem_req}, 32'd0);
      mem_respond();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stall = 1'b0;
      check_val("release_valid", {31'd0, inst_valid}, 32'd1);
      check_val("release_pc", pc_out, exp_pc);
      check_val("release_data", inst_data, exp_pc);
      exp_pc = exp_pc + 32'd4;
      mem_respond();
    end

    // Fresh start for redirect scenarios.
    @(negedge clk);
    reset    = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_respond();
    end
    // Request to 0x10 is left waiting.
    @(negedge clk);
    check_val("rd_addr10", imem_addr, 32'h10);
    imem_ack = 1'b0;
    @(negedge clk);
    check_val("rd_hold_addr", imem_addr, 32'h10);
    check_val("rd_empty", {31'd0, inst_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    check_val("rd_discard_req", {31'd0, imem_req}, 32'd1);
    check_val("rd_discard_addr", imem_addr, 32'h10);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_val("rd_new_addr", imem_addr, 32'h100);
    check_val("rd_new_req", {31'd0, imem_req}, 32'd1);
    check_val("rd_dropped", {31'd0, inst_valid}, 32'd0);
    mem_respond();
    @(negedge clk);
    check_val("rd_first_pc", pc_out, 32'h100);
    check_val("rd_first_data", inst_data, 32'h100);
    check_val("rd_next_addr", imem_addr, 32'h104);

    // Redirect coinciding with ack.
    mem_respond();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    check_val("ra_valid_falls", {31'd0, inst_valid}, 32'd0);
    check_val("ra_addr", imem_addr, 32'h200);
    check_val("ra_req", {31'd0, imem_req}, 32'd1);
    mem_respond();
    @(negedge clk);
    check_val("ra_pc", pc_out, 32'h200);
    check_val("ra_data", inst_data, 32'h200);

    // Mid-transaction reset: WAIT with one queued entry.
    stall    = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    check_val("mr_pre_valid", {31'd0, inst_valid}, 32'd1);
    check_val("mr_pre_addr", imem_addr, 32'h204);
    #1 reset = 1'b1;
    #1 check_reset_outputs("mr");
    @(negedge clk);
    reset      = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    imem_ack = 1'b0;
    check_val("mr_stale_valid", {31'd0, inst_valid}, 32'd0);
    check_val("mr_req", {31'd0, imem_req}, 32'd1);
    check_val("mr_addr", imem_addr, 32'h0);
    @(negedge clk);
    check_val("mr_still_empty", {31'd0, inst_valid}, 32'd0);
    check_val("mr_hold_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
